fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 19 +
 rtl/fetch_sequencer_adder.sv | 10 +
 rtl/fetch_sequencer.sv | 145 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared datapath definitions for the instruction fetch sequencer:
// state encoding, sequential PC step and word-alignment helpers.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    // Redirect targets are forced onto a word boundary before loading the PC.
    function automatic logic [0:31] align_word(input logic [0:31] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_sequencer_adder.sv
// 32-bit modulo adder shared by the fetch PC increment and the pc_next output.
module fetch_sequencer_adder (
    input  logic [0:31] a,
    input  logic [0:31] b,
    output logic [0:31] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem read, a single-entry
// registered output buffer toward decode, and redirect handling with drop.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [0:31] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [0:31] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [0:31] inst_word,
    output logic [0:31] inst_pc,
    output logic [0:31] inst_pc_next,
    input  logic        redirect_valid,
    input  logic [0:31] redirect_target
);

    fetch_state_t state_r;
    fetch_state_t state_s;
    logic [0:31]  pc_r;
    logic [0:31]  pc_s;
    logic [0:31]  pc_inc_s;
    logic [0:31]  step_s;
    logic         drop_r;
    logic         drop_s;
    logic         capture_s;
    logic         release_s;

    assign step_s = PC_STEP;

    fetch_sequencer_adder u_pc_adder (
        .a   (pc_r),
        .b   (step_s),
        .sum (pc_inc_s)
    );

    assign imem_req  = (state_r == ST_REQ);
    assign imem_addr = pc_r;

    // Next-state, next-PC and drop-flag decode; redirect always has priority.
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        drop_s    = drop_r;
        capture_s = 1'b0;
        release_s = 1'b0;
        case (state_r)
            ST_REQ: begin
                if (redirect_valid) begin
                    pc_s = align_word(redirect_target);
                    // The old address was accepted in this same cycle, so its data must be dropped.
                    if (imem_ready) begin
                        state_s = ST_WAIT;
                        drop_s  = 1'b1;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else if (imem_ready) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_s = align_word(redirect_target);
                    if (imem_rvalid) begin
                        state_s = ST_REQ;
                        drop_s  = 1'b0;
                    end else begin
                        state_s = ST_WAIT;
                        drop_s  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop_r) begin
                        state_s = ST_REQ;
                        drop_s  = 1'b0;
                    end else begin
                        state_s   = ST_HOLD;
                        capture_s = 1'b1;
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_s      = align_word(redirect_target);
                    state_s   = ST_REQ;
                    release_s = 1'b1;
                end else if (inst_ready) begin
                    pc_s      = pc_inc_s;
                    state_s   = ST_REQ;
                    release_s = 1'b1;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_REQ;
                drop_s  = 1'b0;
            end
        endcase
    end

    // FSM state, fetch PC and drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_REQ;
            pc_r    <= RESET_PC;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            drop_r  <= drop_s;
        end
    end

    // Registered instruction buffer offered to decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_valid   <= 1'b0;
            inst_word    <= 32'h0000_0000;
            inst_pc      <= 32'h0000_0000;
            inst_pc_next <= 32'h0000_0000;
        end else if (capture_s) begin
            inst_valid   <= 1'b1;
            inst_word    <= imem_rdata;
            inst_pc      <= pc_r;
            inst_pc_next <= pc_inc_s;
        end else if (release_s) begin
            inst_valid   <= 1'b0;
        end else begin
            inst_valid   <= inst_valid;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench: a program-order reference model predicts the sequence of
// offered instructions and fetch addresses; a monitor checks the DUT against it.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [0:31] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [0:31] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [0:31] inst_word;
    logic [0:31] inst_pc;
    logic [0:31] inst_pc_next;
    logic        redirect_valid;
    logic [0:31] redirect_target;

    int total = 0;
    int bad   = 0;

    // memory responder controls and state
    int          ready_pct = 100;
    int          lat_min   = 0;
    int          lat_max   = 0;
    bit          stray_en  = 1'b0;
    bit          pend      = 1'b0;
    int          pend_dly  = 0;
    logic [31:0] pend_addr = 32'h0;

    // scoreboard / model state
    logic [31:0] exp_q[$];
    logic [31:0] cur_pc     = 32'h0;
    bit          prev_valid = 1'b0;
    int          n_offers   = 0;
    int          cyc        = 0;
    int          last_cyc   = 0;
    bit          have_last  = 1'b0;
    bit          spacing_chk = 1'b0;

    fetch_sequencer #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (32'd4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_word       (inst_word),
        .inst_pc         (inst_pc),
        .inst_pc_next    (inst_pc_next),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'h2008_0005;
        else return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_offers(input int n, input int budget);
        int target;
        target = n_offers + n;
        for (int i = 0; i < budget && n_offers < target; i++) step();
        if (n_offers < target) timeout("wait_offer");
    endtask

    task automatic wait_req(input int budget);
        for (int i = 0; i < budget && !imem_req; i++) step();
        if (!imem_req) timeout("wait_req");
    endtask

    task automatic wait_pend(input int budget);
        for (int i = 0; i < budget && !pend; i++) step();
        if (!pend) timeout("wait_pend");
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_valid  = 1'b1;
        redirect_target = t;
        step();
        redirect_valid  = 1'b0;
    endtask

    // Memory model: accepts a request, answers after a random latency, may inject stray rvalids.
    initial begin
        bit          acc;
        logic [31:0] acc_addr;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            acc      = imem_req && imem_ready && !rst;
            acc_addr = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (acc) begin
                pend      = 1'b1;
                pend_addr = acc_addr;
                pend_dly  = $urandom_range(lat_max, lat_min);
            end
            if (pend) begin
                if (pend_dly == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(pend_addr);
                    pend        = 1'b0;
                end else begin
                    pend_dly--;
                end
            end else if (stray_en && $urandom_range(7, 0) == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF ^ $urandom;
            end
            imem_ready = !pend && ($urandom_range(99, 0) < ready_pct);
        end
    end

    // Monitor and reference model: check what the DUT shows, then apply the coming edge's events.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_imem_req", imem_req, 1'b1);
            chk("rst_imem_addr", imem_addr, RESET_PC);
            chk("rst_inst_valid", inst_valid, 1'b0);
            exp_q.delete();
            exp_q.push_back(RESET_PC);
            prev_valid = 1'b0;
            have_last  = 1'b0;
        end else begin
            if (inst_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    timeout("unexpected_offer");
                end else begin
                    cur_pc = exp_q.pop_front();
                    n_offers++;
                    if (spacing_chk && have_last) chk("offer_spacing", cyc - last_cyc, 3);
                    last_cyc  = cyc;
                    have_last = 1'b1;
                end
            end
            if (inst_valid) begin
                chk("inst_pc", inst_pc, cur_pc);
                chk("inst_word", inst_word, mem_word(cur_pc));
                chk("inst_pc_next", inst_pc_next, cur_pc + 32'd4);
                chk("no_req_in_hold", imem_req, 1'b0);
            end
            if (imem_req) begin
                if (exp_q.size() == 0) timeout("unexpected_req");
                else chk("imem_addr", imem_addr, exp_q[0]);
            end
            prev_valid = inst_valid;
            if (redirect_valid) begin
                exp_q.delete();
                exp_q.push_back(redirect_target & 32'hFFFF_FFFC);
            end else if (inst_valid && inst_ready) begin
                exp_q.push_back(cur_pc + 32'd4);
            end
        end
    end

    // Stimulus: directed scenarios followed by a randomized run.
    initial begin
        int base;
        bit last_redir;
        rst             = 1'b1;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        repeat (3) step();

        // sequential fetch from reset, back-to-back consume
        spacing_chk = 1'b1;
        inst_ready  = 1'b1;
        rst         = 1'b0;
        wait_offers(3, 40);
        spacing_chk = 1'b0;

        // stall decode on word 32'h2008_0005
        inst_ready = 1'b0;
        redirect(32'h0000_0200);
        wait_offers(1, 40);
        repeat (5) step();
        chk("stall_valid", inst_valid, 1'b1);
        chk("stall_word", inst_word, 32'h2008_0005);
        chk("stall_no_req", imem_req, 1'b0);
        inst_ready = 1'b1;

        // redirect while a read is outstanding
        lat_min = 3;
        lat_max = 3;
        wait_pend(40);
        redirect(32'h0040_0013);
        wait_req(40);
        chk("wait_redirect_addr", imem_addr, 32'h0040_0010);
        wait_offers(1, 40);

        // redirect and inst_ready in the same HOLD cycle
        lat_min    = 0;
        lat_max    = 0;
        inst_ready = 1'b0;
        wait_offers(1, 40);
        inst_ready = 1'b1;
        redirect(32'h0000_0100);
        wait_req(40);
        chk("hold_redirect_addr", imem_addr, 32'h0000_0100);

        // PC wrap at the top of the address space
        redirect(32'hFFFF_FFFC);
        wait_offers(2, 60);

        // reset in the middle of a read, late rvalid must be ignored
        lat_min = 6;
        lat_max = 6;
        wait_pend(40);
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_reissue_addr", imem_addr, RESET_PC);
        wait_offers(1, 60);

        // randomized traffic
        lat_min    = 0;
        lat_max    = 3;
        ready_pct  = 60;
        stray_en   = 1'b1;
        last_redir = 1'b0;
        base       = n_offers;
        for (int i = 0; i < 600; i++) begin
            inst_ready = ($urandom_range(2, 0) != 0);
            if (!last_redir && $urandom_range(15, 0) == 0) begin
                redirect_valid  = 1'b1;
                redirect_target = $urandom;
                last_redir      = 1'b1;
            end else begin
                redirect_valid = 1'b0;
                last_redir     = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        repeat (10) step();
        chk("random_progress", (n_offers - base) >= 20, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
